// File: rtl/key_filter_if.sv
// Key bundle between the raw push-buttons and the debounce block.
// The master drives key_in, and the slave (key_filter) returns the conditioned events.
interface key_filter_if;
  localparam int unsigned N_KEYS = 4;

  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;

  modport master (
    output key_in,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_filter.sv
// Four-channel active-low key conditioner: each channel has a 2-flop synchroniser and a debounce FSM.
// It produces a registered level, plus press, release and long-press pulses.
module key_filter #(
  parameter logic [19:0] CNT_MAX  = 20'd999_999,
  parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  key_filter_if.slave   kif
);
  localparam int unsigned N_KEYS = 4;
  localparam int unsigned CNT_W  = 20;
  localparam int unsigned HOLD_W = 26;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    DOWN         = 2'd2,
    RELEASE_FILT = 2'd3
  } state_e;

  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [CNT_W-1:0]  fcnt_q  [N_KEYS];
  logic [CNT_W-1:0]  fcnt_d  [N_KEYS];
  logic [HOLD_W-1:0] hold_q  [N_KEYS];
  logic [HOLD_W-1:0] hold_d  [N_KEYS];

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] rel_q,   rel_d;
  logic [N_KEYS-1:0] long_q,  long_d;

  // Synchroniser idles high (released) so reset never looks like a press
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= kif.key_in;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= IDLE;
        fcnt_q[i]  <= '0;
        hold_q[i]  <= '0;
      end
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        fcnt_q[i]  <= fcnt_d[i];
        hold_q[i]  <= hold_d[i];
      end
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  // Per-channel next-state and output decode
  always_comb begin
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    level_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      fcnt_d[i]  = fcnt_q[i];
      hold_d[i]  = hold_q[i];

      // Hold counter runs through release-filter bounces, so a long press fires only once
      if ((state_q[i] == DOWN || state_q[i] == RELEASE_FILT) && hold_q[i] != LONG_MAX) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
        long_d[i] = (hold_q[i] == LONG_MAX - HOLD_W'(1));
      end

      unique case (state_q[i])
        IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESS_FILT;
            fcnt_d[i]  = '0;
          end
        end
        PRESS_FILT: begin
          if (sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (fcnt_q[i] == CNT_MAX) begin
            state_d[i] = DOWN;
            hold_d[i]  = '0;
            press_d[i] = 1'b1;
          end else begin
            fcnt_d[i] = fcnt_q[i] + CNT_W'(1);
          end
        end
        DOWN: begin
          if (sync2_q[i]) begin
            state_d[i] = RELEASE_FILT;
            fcnt_d[i]  = '0;
          end
        end
        RELEASE_FILT: begin
          if (!sync2_q[i]) begin
            state_d[i] = DOWN;
          end else if (fcnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
            rel_d[i]   = 1'b1;
          end else begin
            fcnt_d[i] = fcnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase

      level_d[i] = (state_d[i] == DOWN) || (state_d[i] == RELEASE_FILT);
    end
  end

  assign kif.key_state   = level_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = rel_q;
  assign kif.key_long    = long_q;
endmodule

// File: doc/key_filter.md
# key_filter

Four-channel push-button input conditioner for the board's active-low keys: the input side of the LED output path. Each raw key is synchronised and debounced by a per-channel state machine. The block emits a debounced level plus one-cycle press, release and long-press pulses. These pulses are the control events for LED pattern blocks such as the running-light driver.

## Interface
- CNT_MAX, 20'd999_999, debounce window minus one, in sys_clk cycles (20 ms at 50 MHz).
- LONG_MAX, 26'd49_999_999, hold time from press to the long-press pulse, in sys_clk cycles (1 s at 50 MHz).
- sys_clk  input  1  the single system clock; all logic rises on it.
- sys_rst_n  input  1  asynchronous active-low reset.
- key_in  input  4  raw asynchronous key inputs, 0 = pressed.
- key_state  output  4  debounced level, 1 = pressed.
- key_press  output  4  one-cycle pulse per debounced press.
- key_release  output  4  one-cycle pulse per debounced release.
- key_long  output  4  one-cycle pulse once per press that is held LONG_MAX cycles.

## Operation
- Synchroniser: two flops per channel, reset to 1. The FSM sees only the second flop, key_s[i].
- Each channel has its own FSM, a 20-bit filter counter and a 26-bit hold counter. Channels are fully independent.
- IDLE
  - key_s=0: go to PRESS_FILT with the filter counter at 0.
- PRESS_FILT
  - key_s=1 (bounce): return to IDLE, no pulse.
  - Else, filter counter == CNT_MAX: go to DOWN, clear the hold counter, assert key_press for one cycle.
  - Else: increment the filter counter.
- DOWN
  - key_s=1: go to RELEASE_FILT with the filter counter at 0.
- RELEASE_FILT
  - key_s=0 (bounce): return to DOWN, no pulse.
  - Else, filter counter == CNT_MAX: go to IDLE, assert key_release for one cycle.
  - Else: increment the filter counter.
- Hold counter
  - Increments every cycle in DOWN and RELEASE_FILT.
  - Saturates at LONG_MAX.
  - On the edge where it steps from LONG_MAX-1 to LONG_MAX, key_long pulses for one cycle.
  - It is not cleared by a release-filter bounce, so key_long fires at most once per press.
  - If the key is released before LONG_MAX, key_long does not fire.
- key_state = 1 in DOWN and RELEASE_FILT, 0 in IDLE and PRESS_FILT.
- All outputs are registered. No combinational path from key_in.
- Reset, including mid-operation:
  - All FSMs go to IDLE and all counters to 0.
  - Synchroniser flops go to 1.
  - All outputs go to 0.
  - A key held through reset is treated as a new press and produces key_press after a full filter window.
- Filter counter never exceeds CNT_MAX. No wrap.

## Timing
- Edge 1 is the first sys_clk edge that samples key_in low. With the input stable, the FSM enters PRESS_FILT at edge 3.
- key_press is high in the cycle after edge CNT_MAX+4. key_state rises at the same edge.
- key_release is high in the cycle after edge CNT_MAX+4, counted from the first edge sampling key_in high. key_state falls at the same edge.
- key_long rises exactly LONG_MAX cycles after the key_press rising edge.
- Any input glitch shorter than CNT_MAX+1 consecutive FSM-sampled cycles produces no pulse and no key_state change.
- Pulses on several channels in the same cycle are legal and independent.
- A key_press and key_long on the same channel never coincide, because LONG_MAX ≥ 1.

## Test plan
Run all scenarios with CNT_MAX=9 and LONG_MAX=49.
- Reset held with key_in=4'b1111, then released: all outputs remain 0; no pulse for 100 cycles.
- key_in[0] driven low cleanly at edge 1: key_press=4'b0001 for exactly one cycle after edge 13; key_state[0]=1 from then on.
- key_in[1] toggled low/high every 4 cycles for 40 cycles, then held low: no pulse during the bounce; exactly one key_press[1] 13 edges after the last low transition.
- key_in[2] held low for 80 cycles after press: key_long[2] fires once, 49 cycles after key_press[2]; key_in[2] then released: key_release[2] fires 13 edges later and key_state[2] returns to 0.
- key_in[3] pressed, then during DOWN a 5-cycle high glitch: no key_release; key_long[3] still fires once at press+49.
- All four keys pressed on the same edge: key_press=4'b1111 in the same cycle; sys_rst_n pulsed low mid-hold: outputs go to 0 immediately; after reset exits, key_press=4'b1111 again after a full filter window.
